jzjpcc_mem_arbiter: RTL and testbench

Shares the single memory port between the fetch stage and the execute/memory stage's load/store path. Accepts one request from each side, grants one transaction at a time with fixed data priority plus a fetch anti-starvation limit, drives the memory handshake from registered state, and returns read data and a done pulse to the winning requester. Write data and byte mask arrive already lane-aligned from the execute-stage memory processor.

---
 rtl/jzjpcc_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_jzjpcc_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jzjpcc_mem_arbiter.sv
// jzjpcc_mem_arbiter: shares one memory port between instruction fetch and the
// load/store path. One transaction is in flight at a time. Data requests win
// by default; after STARVE_LIMIT consecutive data grants with fetch waiting,
// fetch wins the next contended arbitration.
//
// Ports:
//   clock, reset_n              rising-edge clock, async active-low reset
//   if_req/if_addr              fetch request and byte address
//   if_done/if_rdata            fetch completion pulse and fetched word
//   d_req/d_we/d_addr           load/store request, direction, byte address
//   d_wdata/d_byteMask          lane-aligned store data and byte enables
//   d_done/d_rdata              data completion pulse and load word
//   mem_req/mem_we/mem_addr     memory request, write enable, word address
//   mem_wdata/mem_byteMask      memory write data and byte enables
//   mem_ack/mem_rdata           memory completion and read data
module jzjpcc_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byteMask,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byteMask,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             req_nxt, we_nxt;
    logic [29:0]      addr_nxt;
    logic [31:0]      wdata_nxt;
    logic [3:0]       mask_nxt;
    logic             if_done_nxt, d_done_nxt;
    logic [31:0]      if_rdata_nxt, d_rdata_nxt;

    // Byte-offset bits of both addresses are not used for word accesses.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

    // A side that is completing this cycle still shows its old req; ignore it.
    logic if_ok, d_ok, grant_f, grant_d;
    assign if_ok   = if_req && !if_done;
    assign d_ok    = d_req && !d_done;
    assign grant_f = (state == S_IDLE) && if_ok && (!d_ok || (cnt == LIMIT));
    assign grant_d = (state == S_IDLE) && d_ok && !grant_f;

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        req_nxt      = mem_req;
        we_nxt       = mem_we;
        addr_nxt     = mem_addr;
        wdata_nxt    = mem_wdata;
        mask_nxt     = mem_byteMask;
        if_done_nxt  = 1'b0;
        d_done_nxt   = 1'b0;
        if_rdata_nxt = if_rdata;
        d_rdata_nxt  = d_rdata;
        case (state)
            S_IDLE: begin
                if (grant_f) begin
                    state_nxt = S_FETCH;
                    req_nxt   = 1'b1;
                    we_nxt    = 1'b0;
                    addr_nxt  = if_addr[31:2];
                    wdata_nxt = 32'h0;
                    mask_nxt  = 4'hF;
                    cnt_nxt   = '0;
                end else if (grant_d) begin
                    state_nxt = S_DATA;
                    req_nxt   = 1'b1;
                    we_nxt    = d_we;
                    addr_nxt  = d_addr[31:2];
                    wdata_nxt = d_wdata;
                    mask_nxt  = d_we ? d_byteMask : 4'hF;
                    if (if_req && (cnt < LIMIT)) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    state_nxt    = S_IDLE;
                    req_nxt      = 1'b0;
                    if_done_nxt  = 1'b1;
                    if_rdata_nxt = mem_rdata;
                end
            end
            S_DATA: begin
                if (mem_ack) begin
                    state_nxt  = S_IDLE;
                    req_nxt    = 1'b0;
                    d_done_nxt = 1'b1;
                    if (!mem_we) begin
                        d_rdata_nxt = mem_rdata;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                req_nxt   = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_byteMask <= '0;
            if_done      <= 1'b0;
            d_done       <= 1'b0;
            if_rdata     <= '0;
            d_rdata      <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            mem_req      <= req_nxt;
            mem_we       <= we_nxt;
            mem_addr     <= addr_nxt;
            mem_wdata    <= wdata_nxt;
            mem_byteMask <= mask_nxt;
            if_done      <= if_done_nxt;
            d_done       <= d_done_nxt;
            if_rdata     <= if_rdata_nxt;
            d_rdata      <= d_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_jzjpcc_mem_arbiter.sv
// Testbench for jzjpcc_mem_arbiter: random requesters and memory, a
// transaction-level arbitration model that predicts grants and completions,
// and an independent monitor that checks the DUT against those predictions.
module tb_jzjpcc_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_byteMask = '0;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byteMask;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    jzjpcc_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byteMask(d_byteMask), .d_done(d_done), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_byteMask(mem_byteMask),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic        we;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } mem_exp_t;

    typedef struct {
        int unsigned cyc;
        logic        fetch;
        logic [31:0] rdata;
    } done_exp_t;

    mem_exp_t  exp_mem[$];
    done_exp_t exp_done[$];

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic flag(input string name, input logic [63:0] act);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: actual 0x%0h (cycle %0d)", name, act, cyc);
    endtask

    // Model and agent state, owned by the stimulus process.
    bit busy = 0, cur_f = 0, cur_we = 0, fin_pending = 0, fin_f = 0;
    int cnt = 0;
    int stale = 0;                 // 0 none, 1 fetch, 2 data
    logic [31:0] last_d = '0;
    bit f_out = 0, d_out = 0, d_granted = 0;
    bit allow_new = 0, contend = 0, mem_hold = 0;
    int mem_wait = -1;
    bit dir_f = 0, dir_d = 0;
    logic [31:0] dir_f_addr = '0, dir_d_addr = '0, dir_d_wdata = '0;
    logic dir_d_we = 0;
    logic [3:0] dir_d_mask = '0;

    // One cycle of requesters, memory and reference model, at the falling edge.
    task automatic step();
        logic s_req, s_ifd, s_dd;
        bit ef, ed;
        int winner;
        mem_exp_t me;
        done_exp_t de;
        @(negedge clock);
        s_req = mem_req;
        s_ifd = if_done;
        s_dd  = d_done;
        stale = 0;
        if (fin_pending) begin
            busy = 0;
            fin_pending = 0;
            stale = fin_f ? 1 : 2;
        end
        // Memory: answers the transaction currently presented.
        mem_ack = 1'b0;
        if (s_req) begin
            check("mem_req_while_model_busy", 64'(busy), 64'(1));
            if (mem_wait < 0) mem_wait = contend ? 0 : int'($urandom_range(0, 3));
            if (mem_hold) begin
                mem_ack = 1'b0;
            end else if (mem_wait == 0) begin
                mem_ack = 1'b1;
                mem_rdata = $urandom;
                mem_wait = -1;
                fin_pending = 1;
                fin_f = cur_f;
                de.cyc = cyc + 1;
                de.fetch = cur_f;
                if (cur_f) de.rdata = mem_rdata;
                else if (cur_we) de.rdata = last_d;
                else begin
                    last_d = mem_rdata;
                    de.rdata = mem_rdata;
                end
                exp_done.push_back(de);
            end else begin
                mem_wait--;
            end
        end else begin
            mem_wait = -1;
            mem_ack = (!contend && $urandom_range(0, 4) == 0);
            mem_rdata = $urandom;
        end
        // Fetch requester.
        if (s_ifd) begin
            f_out = 0;
            if_req = 1'b0;
        end
        if (!f_out && dir_f) begin
            dir_f = 0;
            f_out = 1;
            if_req = 1'b1;
            if_addr = dir_f_addr;
        end else if (!f_out && allow_new && (contend || $urandom_range(0, 2) == 0)) begin
            f_out = 1;
            if_req = 1'b1;
            if_addr = {1'b0, 31'($urandom)};
        end
        // Data requester; may withdraw req once its transaction is granted.
        if (s_dd) begin
            d_out = 0;
            d_granted = 0;
            d_req = 1'b0;
        end else if (d_granted && d_req && !contend && $urandom_range(0, 3) == 0) begin
            d_req = 1'b0;
        end
        if (!d_out && dir_d) begin
            dir_d = 0;
            d_out = 1;
            d_req = 1'b1;
            d_we = dir_d_we;
            d_addr = dir_d_addr;
            d_wdata = dir_d_wdata;
            d_byteMask = dir_d_mask;
        end else if (!d_out && allow_new && (contend || $urandom_range(0, 2) == 0)) begin
            d_out = 1;
            d_req = 1'b1;
            d_we = 1'($urandom);
            d_addr = {1'b1, 31'($urandom)};
            d_wdata = $urandom;
            d_byteMask = 4'($urandom);
        end
        // Arbitration: data first, fetch after LIMIT data grants while waiting.
        if (!busy) begin
            ef = if_req && (stale != 1);
            ed = d_req && (stale != 2);
            winner = 0;
            if (ef && ed) winner = (cnt == LIMIT) ? 1 : 2;
            else if (ef) winner = 1;
            else if (ed) winner = 2;
            if (winner != 0) begin
                me.cyc = cyc + 1;
                busy = 1;
                cur_f = (winner == 1);
                if (cur_f) begin
                    me.we = 1'b0;
                    me.addr = if_addr[31:2];
                    me.wdata = '0;
                    me.mask = 4'hF;
                    cnt = 0;
                end else begin
                    me.we = d_we;
                    me.addr = d_addr[31:2];
                    me.wdata = d_wdata;
                    me.mask = d_we ? d_byteMask : 4'hF;
                    if (if_req && cnt < LIMIT) cnt++;
                    d_granted = 1;
                end
                cur_we = me.we;
                exp_mem.push_back(me);
            end
        end
    endtask

    task automatic drain();
        int n;
        allow_new = 0;
        n = 0;
        while ((busy || fin_pending || f_out || d_out || dir_f || dir_d) && n < 300) begin
            step();
            n++;
        end
        if (busy || fin_pending || f_out || d_out) flag("drain_timeout", 64'(n));
    endtask

    // Monitor: compares what the DUT presents with the queued predictions.
    mem_exp_t cur;
    bit have_cur = 0;
    logic [31:0] hold_if = '0, hold_d = '0;
    initial begin
        done_exp_t e;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                have_cur = 0;
                hold_if = '0;
                hold_d = '0;
                continue;
            end
            if (mem_req) begin
                if (!have_cur) begin
                    if (exp_mem.size() == 0) flag("mem_req_unexpected", 64'(mem_addr));
                    else begin
                        cur = exp_mem.pop_front();
                        have_cur = 1;
                        check("grant_cycle", 64'(cyc), 64'(cur.cyc));
                    end
                end
                if (have_cur) begin
                    check("mem_we", 64'(mem_we), 64'(cur.we));
                    check("mem_addr", 64'(mem_addr), 64'(cur.addr));
                    check("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
                    check("mem_byteMask", 64'(mem_byteMask), 64'(cur.mask));
                end
            end else begin
                have_cur = 0;
            end
            if (if_done && d_done) flag("both_done", 64'(3));
            if (if_done || d_done) begin
                if (exp_done.size() == 0) flag("done_unexpected", 64'({if_done, d_done}));
                else begin
                    e = exp_done.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                    check("done_is_fetch", 64'(if_done), 64'(e.fetch));
                    if (e.fetch) hold_if = e.rdata;
                    else hold_d = e.rdata;
                end
            end
            check("if_rdata", 64'(if_rdata), 64'(hold_if));
            check("d_rdata", 64'(d_rdata), 64'(hold_d));
        end
    end

    initial begin
        int n;
        repeat (2) @(negedge clock);
        #1;
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_mem_byteMask", 64'(mem_byteMask), 64'(0));
        check("rst_if_done", 64'(if_done), 64'(0));
        check("rst_d_done", 64'(d_done), 64'(0));
        check("rst_if_rdata", 64'(if_rdata), 64'(0));
        check("rst_d_rdata", 64'(d_rdata), 64'(0));
        @(negedge clock);
        #2 reset_n = 1'b1;

        // Directed load, store and fetch.
        dir_d = 1; dir_d_we = 0; dir_d_addr = 32'h0000_1004; dir_d_wdata = '0; dir_d_mask = 4'h0;
        drain();
        dir_d = 1; dir_d_we = 1; dir_d_addr = 32'h0000_0008; dir_d_wdata = 32'h0000_AB00; dir_d_mask = 4'b0010;
        drain();
        dir_f = 1; dir_f_addr = 32'h0000_0103;
        drain();

        // Both sides requesting back to back with zero-wait memory.
        contend = 1;
        allow_new = 1;
        repeat (40) step();
        contend = 0;
        drain();

        // Random traffic, wait states, withdrawals, spurious acks.
        allow_new = 1;
        repeat (3000) step();
        drain();

        // Reset while a load is waiting for its ack.
        mem_hold = 1;
        dir_d = 1; dir_d_we = 0; dir_d_addr = 32'h8000_0040; dir_d_wdata = '0; dir_d_mask = 4'hF;
        n = 0;
        while (!mem_req && n < 10) begin
            step();
            n++;
        end
        if (!mem_req) flag("reset_test_no_req", 64'(n));
        step();
        #2 reset_n = 1'b0;
        #1;
        check("midrst_mem_req", 64'(mem_req), 64'(0));
        check("midrst_mem_addr", 64'(mem_addr), 64'(0));
        check("midrst_mem_byteMask", 64'(mem_byteMask), 64'(0));
        check("midrst_d_done", 64'(d_done), 64'(0));
        check("midrst_if_rdata", 64'(if_rdata), 64'(0));
        check("midrst_d_rdata", 64'(d_rdata), 64'(0));
        mem_ack = 1'b0;
        if_req = 1'b0;
        d_req = 1'b0;
        busy = 0; fin_pending = 0; cnt = 0; last_d = '0;
        f_out = 0; d_out = 0; d_granted = 0; mem_hold = 0; mem_wait = -1;
        exp_mem.delete();
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;
        dir_f = 1; dir_f_addr = 32'h0000_0103;
        drain();

        repeat (3) @(negedge clock);
        #1;
        check("exp_mem_left", 64'(exp_mem.size()), 64'(0));
        check("exp_done_left", 64'(exp_done.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
